uart_rx_edge_sampler: RTL and testbench
=======================================

Name: uart_rx_edge_sampler

Overview:
Oversampling front end of the UART receiver, directly upstream of the Rx control FSM.
- Synchronizes the raw serial line into the UCLK domain and counts oversampling edges within each bit period.
- Takes a 3-point majority-vote sample near mid-bit.
- Supplies the serial line level, edge_count, edge_count_done and the voted bit to the control unit and the check/deserializer stages.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on serial_in (legal values 2..3)
DEFAULT_PRESCALE, 16, effective prescale substituted when the prescale input is illegal

Ports:
clk  input  1  receiver oversampling clock (UCLK)
reset  input  1  asynchronous, active-low reset
enable  input  1  edge_counter_and_data_sampler_enable from the control FSM
prescale  input  6  oversampling ratio (edges per bit)
serial_in  input  1  raw, asynchronous Rx line
serial_sync  output  1  synchronized line level, to control FSM serial_data_in
edge_count  output  5  current edge index within the bit, 0..eff_prescale-1
edge_count_done  output  1  high during the last edge of the bit period
sampled_bit  output  1  majority-voted bit value
sample_valid  output  1  one-cycle strobe: sampled_bit freshly updated
prescale_error  output  1  latched prescale was illegal and DEFAULT_PRESCALE is in use

Behaviour:
- Reset (asynchronous, reset=0):
  - synchronizer flops = 1 (idle line), serial_sync=1
  - edge_count=0, edge_count_done=0, sample_valid=0
  - sampled_bit=1, sample register=3'b111
  - eff_prescale=DEFAULT_PRESCALE, prescale_error=0
- Synchronizer: SYNC_STAGES flops clocked by clk. serial_sync is the last flop, so it has SYNC_STAGES cycles of latency. The synchronizer runs regardless of enable.
- Prescale latch:
  - While enable=0, eff_prescale is loaded every cycle from prescale.
  - Legal prescale values are even values 6..32. Otherwise eff_prescale=DEFAULT_PRESCALE and prescale_error=1; prescale_error=0 when the value is legal.
  - While enable=1, eff_prescale and prescale_error are frozen. A prescale change mid-frame is ignored.
  - Derived values: term = eff_prescale-1; half = eff_prescale>>1. Compute term in 6 bits and compare against the zero-extended edge_count. term is at most 31.
- Edge counter (registered):
  - enable=0: edge_count <= 0.
  - enable=1 and edge_count==term: edge_count <= 0 (wrap).
  - Otherwise edge_count <= edge_count+1.
  - The first enabled cycle shows edge_count=0.
- edge_count_done is combinational: enable & (edge_count==term). It is high for exactly one cycle per bit period.
- Sampling:
  - Sample points are the cycles where enable=1 and edge_count is half-1, half or half+1.
  - At the end of cycles half-1 and half, serial_sync is shifted into the sample register.
  - At the end of cycle half+1, sampled_bit <= majority of the two stored samples and the current serial_sync.
- sample_valid is combinational: enable & (edge_count==half+2). In that cycle sampled_bit already holds the new vote. half+2 <= term for every legal prescale.
- sampled_bit holds its value between votes and while enable=0.
- enable deasserted mid-bit:
  - The next cycle shows edge_count=0 and the sample register is cleared to 3'b111.
  - sampled_bit is unchanged and no sample_valid is produced.
  - Re-enable restarts counting at 0.
- enable held high across bits: counting is continuous with no dead cycle between bit periods.
- Example, eff_prescale=8: samples at edges 3,4,5; sample_valid at 6; edge_count_done at 7.

Test Plan:
- prescale=8, enable high 16 cycles, serial_in held 0 -> edge_count 0..7,0..7; done at counts 7 (cycles 7,15); sample_valid at count 6; sampled_bit=0 from count 6 of bit 0.
- prescale=16, line 1 with a single-cycle 0 glitch aligned to edge 7 (half-1) after synchronizer latency -> majority gives sampled_bit=1; with 0 held over edges 7 and 8 -> sampled_bit=0.
- prescale=32 -> edge_count reaches 31, done at 31, wraps to 0; samples at 15,16,17; valid at 18.
- prescale=7 (and separately 40, 4) latched -> prescale_error=1; counter wraps at 15, valid at 10; prescale=8 later with enable=0 -> prescale_error=0.
- enable drops at edge_count=5 (prescale=16) -> next cycle edge_count=0, no sample_valid or done, sampled_bit unchanged; re-enable restarts at 0.
- reset asserted at edge_count=9 with sampled_bit=0 -> immediately edge_count=0, sampled_bit=1, serial_sync=1, prescale_error=0; prescale changed 16->8 while enable=1 -> wrap stays at 15.

Source files
------------

// File: rtl/uart_rx_edge_sampler.sv
// rtl/uart_rx_edge_sampler.sv - UART Rx oversampling front end: line synchronizer, edge counter, 3-point majority sampler
module uart_rx_edge_sampler #(
    parameter int SYNC_STAGES      = 2,
    parameter int DEFAULT_PRESCALE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [5:0] prescale,
    input  logic       serial_in,
    output logic       serial_sync,
    output logic [4:0] edge_count,
    output logic       edge_count_done,
    output logic       sampled_bit,
    output logic       sample_valid,
    output logic       prescale_error
);

    localparam logic [5:0] DEF_PS = 6'(DEFAULT_PRESCALE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [5:0]             eff_ps_q, eff_ps_d;
    logic                   err_q, err_d;
    logic [4:0]             ec_q, ec_d;
    logic [1:0]             samp_q, samp_d;
    logic                   sb_q, sb_d;

    logic [5:0] term, half, ec_ext;
    logic       ps_legal, at_term, at_s0, at_s1, at_vote, at_valid;

    // Idle line is high, so the synchronizer resets to ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign serial_sync = sync_q[SYNC_STAGES-1];

    assign ps_legal = !prescale[0] && (prescale >= 6'd6) && (prescale <= 6'd32);
    assign term     = eff_ps_q - 6'd1;
    assign half     = {1'b0, eff_ps_q[5:1]};
    assign ec_ext   = {1'b0, ec_q};
    assign at_term  = (ec_ext == term);
    assign at_s0    = (ec_ext == half - 6'd1);
    assign at_s1    = (ec_ext == half);
    assign at_vote  = (ec_ext == half + 6'd1);
    assign at_valid = (ec_ext == half + 6'd2);

    always_comb begin
        eff_ps_d = eff_ps_q;
        err_d    = err_q;
        ec_d     = ec_q + 5'd1;
        samp_d   = samp_q;
        sb_d     = sb_q;
        if (!enable) begin
            // Prescale tracks the input only between frames.
            eff_ps_d = ps_legal ? prescale : DEF_PS;
            err_d    = !ps_legal;
            ec_d     = 5'd0;
            samp_d   = 2'b11;
        end else begin
            if (at_term) begin
                ec_d = 5'd0;
            end
            if (at_s0 || at_s1) begin
                samp_d = {samp_q[0], serial_sync};
            end
            if (at_vote) begin
                sb_d = (samp_q[1] & samp_q[0]) | (samp_q[1] & serial_sync) |
                       (samp_q[0] & serial_sync);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eff_ps_q <= DEF_PS;
            err_q    <= 1'b0;
            ec_q     <= 5'd0;
            samp_q   <= 2'b11;
            sb_q     <= 1'b1;
        end else begin
            eff_ps_q <= eff_ps_d;
            err_q    <= err_d;
            ec_q     <= ec_d;
            samp_q   <= samp_d;
            sb_q     <= sb_d;
        end
    end

    assign edge_count      = ec_q;
    assign edge_count_done = enable & at_term;
    assign sample_valid    = enable & at_valid;
    assign sampled_bit     = sb_q;
    assign prescale_error  = err_q;

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// tb/tb_uart_rx_edge_sampler.sv - directed vector bench for uart_rx_edge_sampler
module tb_uart_rx_edge_sampler;

    logic       clk = 1'b0;
    logic       reset, enable, serial_in;
    logic [5:0] prescale;
    logic       serial_sync, edge_count_done, sampled_bit, sample_valid, prescale_error;
    logic [4:0] edge_count;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_edge_sampler #(.SYNC_STAGES(2), .DEFAULT_PRESCALE(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .prescale       (prescale),
        .serial_in      (serial_in),
        .serial_sync    (serial_sync),
        .edge_count     (edge_count),
        .edge_count_done(edge_count_done),
        .sampled_bit    (sampled_bit),
        .sample_valid   (sample_valid),
        .prescale_error (prescale_error)
    );

    typedef struct {
        logic       en;
        logic [5:0] ps;
        logic       si;
        logic [4:0] ec;
        logic       done;
        logic       valid;
        logic       sb;
        logic       ss;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic en, input logic [5:0] ps, input logic si);
        @(posedge clk);
        #1;
        enable    = en;
        prescale  = ps;
        serial_in = si;
        #1;
    endtask

    task automatic chk_frame(input int ec, input int p, input logic sb_exp);
        chk("edge_count", edge_count, ec);
        chk("edge_count_done", edge_count_done, (ec == p - 1));
        chk("sample_valid", sample_valid, (ec == p / 2 + 2));
        if (ec == p / 2 + 2) chk("sampled_bit", sampled_bit, sb_exp);
    endtask

    initial begin
        // prescale=8, line held low: pre-roll with enable low, then two bit periods
        tbl.push_back(vec_t'{1'b0, 6'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 6'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b0, 6'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 6'd8, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 6'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        reset     = 1'b1;
        enable    = 1'b0;
        prescale  = 6'd16;
        serial_in = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_edge_count", edge_count, 0);
        chk("rst_done", edge_count_done, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_sampled_bit", sampled_bit, 1);
        chk("rst_serial_sync", serial_sync, 1);
        chk("rst_prescale_error", prescale_error, 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].en, tbl[i].ps, tbl[i].si);
            chk("tbl_edge_count", edge_count, tbl[i].ec);
            chk("tbl_done", edge_count_done, tbl[i].done);
            chk("tbl_valid", sample_valid, tbl[i].valid);
            chk("tbl_sampled_bit", sampled_bit, tbl[i].sb);
            chk("tbl_serial_sync", serial_sync, tbl[i].ss);
            chk("tbl_prescale_error", prescale_error, tbl[i].err);
        end

        // prescale=16: one-cycle glitch at edge 7 is outvoted; two-cycle low wins
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'd16, 1'b1);
        chk("glitch_pre_sync", serial_sync, 1);
        for (int i = 0; i < 32; i++) begin
            int  ec;
            logic si;
            ec = i % 16;
            si = (i < 16) ? (ec != 5) : !(ec == 5 || ec == 6);
            cyc(1'b1, 6'd16, si);
            if (i == 0) chk("sb_hold_disabled", sampled_bit, 0);
            if (i == 7) chk("glitch_sync_low", serial_sync, 0);
            chk_frame(ec, 16, (i < 16) ? 1'b1 : 1'b0);
        end

        // prescale=32: full-width counter
        cyc(1'b0, 6'd32, 1'b1);
        cyc(1'b0, 6'd32, 1'b1);
        chk("ps32_error", prescale_error, 0);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 6'd32, 1'b1);
            chk_frame(i % 32, 32, 1'b1);
        end

        // illegal prescales fall back to 16
        cyc(1'b0, 6'd7, 1'b1);
        cyc(1'b0, 6'd7, 1'b1);
        chk("ps7_error", prescale_error, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 6'd7, 1'b1);
            chk_frame(i, 16, 1'b1);
        end
        cyc(1'b0, 6'd40, 1'b1);
        cyc(1'b0, 6'd40, 1'b1);
        chk("ps40_error", prescale_error, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 6'd40, 1'b1);
            chk_frame(i, 16, 1'b1);
        end
        cyc(1'b0, 6'd4, 1'b1);
        cyc(1'b0, 6'd4, 1'b1);
        chk("ps4_error", prescale_error, 1);
        cyc(1'b0, 6'd8, 1'b1);
        cyc(1'b0, 6'd8, 1'b1);
        chk("ps8_error_clear", prescale_error, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 6'd8, 1'b1);
            chk_frame(i, 8, 1'b1);
        end

        // enable drops at edge 5 of a prescale=16 bit
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'd16, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 6'd16, 1'b0);
            chk_frame(i, 16, 1'b1);
        end
        cyc(1'b0, 6'd16, 1'b0);
        chk("drop_edge_count", edge_count, 5);
        chk("drop_done", edge_count_done, 0);
        chk("drop_valid", sample_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 6'd16, 1'b0);
            chk("drop_idle_count", edge_count, 0);
            chk("drop_idle_valid", sample_valid, 0);
            chk("drop_sb_hold", sampled_bit, 1);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 6'd16, 1'b0);
            chk_frame(i, 16, 1'b0);
        end

        // asynchronous reset mid-bit with sampled_bit low
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 6'd16, 1'b0);
            chk_frame(i, 16, 1'b0);
        end
        chk("pre_reset_sb", sampled_bit, 0);
        reset = 1'b0;
        #1;
        chk("arst_edge_count", edge_count, 0);
        chk("arst_sampled_bit", sampled_bit, 1);
        chk("arst_serial_sync", serial_sync, 1);
        chk("arst_prescale_error", prescale_error, 0);
        enable = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;

        // prescale change while enabled is ignored
        cyc(1'b0, 6'd16, 1'b1);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, (i < 4) ? 6'd16 : 6'd8, 1'b1);
            chk_frame(i % 16, 16, 1'b1);
        end
        cyc(1'b0, 6'd16, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
